// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// branch flush and a saturating hazard-bubble counter.
package id_ex_pkg;
    typedef struct packed {
        logic       valid;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;
endpackage

module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             id_valid_i,
    input  logic             id_MemRead_i,
    input  logic             id_MemtoReg_i,
    input  logic [1:0]       id_ALUOp_i,
    input  logic             id_MemWrite_i,
    input  logic             id_ALUSrc_i,
    input  logic             id_RegWrite_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [9:0]       id_funct_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    output logic             stall_o,
    output logic             ex_valid_o,
    output logic             ex_MemRead_o,
    output logic             ex_MemtoReg_o,
    output logic [1:0]       ex_ALUOp_o,
    output logic             ex_MemWrite_o,
    output logic             ex_ALUSrc_o,
    output logic             ex_RegWrite_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [9:0]       ex_funct_o,
    output logic [4:0]       ex_rs1_o,
    output logic [4:0]       ex_rs2_o,
    output logic [4:0]       ex_rd_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl_q;
    ctrl_t ctrl_d;

    logic [XLEN-1:0]  rs1_data_q;
    logic [XLEN-1:0]  rs2_data_q;
    logic [XLEN-1:0]  imm_q;
    logic [9:0]       funct_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [4:0]       rd_q;
    logic [4:0]       rd_d;
    logic [CNT_W-1:0] cnt_q;

    logic rs1_match;
    logic rs2_match;
    logic hazard;
    logic squash;
    logic cnt_inc;

    always_comb begin
        id_ctrl            = '0;
        id_ctrl.valid      = id_valid_i;
        id_ctrl.mem_read   = id_MemRead_i;
        id_ctrl.mem_to_reg = id_MemtoReg_i;
        id_ctrl.alu_op     = id_ALUOp_i;
        id_ctrl.mem_write  = id_MemWrite_i;
        id_ctrl.alu_src    = id_ALUSrc_i;
        id_ctrl.reg_write  = id_RegWrite_i;
    end

    // rs2 only matters when it is an ALU operand or store data
    assign rs1_match = (rd_q == id_rs1_i);
    assign rs2_match = (rd_q == id_rs2_i)
                     & (~id_ALUSrc_i | id_MemWrite_i);

    assign hazard = ex_ctrl_q.valid
                  & ex_ctrl_q.mem_read
                  & (rd_q != 5'd0)
                  & id_valid_i
                  & (rs1_match | rs2_match);

    assign stall_o = hazard & start_i & ~flush_i;

    assign squash  = flush_i | hazard | ~id_valid_i;
    assign cnt_inc = hazard & ~flush_i & ~(&cnt_q);

    always_comb begin
        ctrl_d = id_ctrl;
        rd_d   = id_rd_i;
        if (squash) begin
            ctrl_d = '0;
            rd_d   = 5'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_ctrl_q  <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            funct_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else if (start_i) begin
            ex_ctrl_q  <= ctrl_d;
            rs1_data_q <= id_rs1_data_i;
            rs2_data_q <= id_rs2_data_i;
            imm_q      <= id_imm_i;
            funct_q    <= id_funct_i;
            rs1_q      <= id_rs1_i;
            rs2_q      <= id_rs2_i;
            rd_q       <= rd_d;
            if (cnt_inc)
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ex_valid_o    = ex_ctrl_q.valid;
    assign ex_MemRead_o  = ex_ctrl_q.mem_read;
    assign ex_MemtoReg_o = ex_ctrl_q.mem_to_reg;
    assign ex_ALUOp_o    = ex_ctrl_q.alu_op;
    assign ex_MemWrite_o = ex_ctrl_q.mem_write;
    assign ex_ALUSrc_o   = ex_ctrl_q.alu_src;
    assign ex_RegWrite_o = ex_ctrl_q.reg_write;
    assign ex_rs1_data_o = rs1_data_q;
    assign ex_rs2_data_o = rs2_data_q;
    assign ex_imm_o      = imm_q;
    assign ex_funct_o    = funct_q;
    assign ex_rs1_o      = rs1_q;
    assign ex_rs2_o      = rs2_q;
    assign ex_rd_o       = rd_q;
    assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: model predicts EX state and stall,
// expected values are queued at drive time and popped after each edge.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        mr;
        logic        m2r;
        logic [1:0]  op;
        logic        mw;
        logic        as;
        logic        rw;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b1;
    logic        flush = 1'b0;
    logic        v, mr, m2r, mw, as, rw;
    logic [1:0]  op;
    logic [31:0] d1, d2, imm;
    logic [9:0]  funct;
    logic [4:0]  rs1, rs2, rd;

    logic        stall, stall2;
    logic        e_v, e_mr, e_m2r, e_mw, e_as, e_rw;
    logic [1:0]  e_op;
    logic [31:0] e_d1, e_d2, e_imm;
    logic [9:0]  e_funct;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [15:0] cnt;
    logic        s_v, s_mr, s_m2r, s_mw, s_as, s_rw;
    logic [1:0]  s_op;
    logic [31:0] s_d1, s_d2, s_imm;
    logic [9:0]  s_funct;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [1:0]  cnt2;

    int   checks = 0;
    int   errors = 0;
    exp_t m;
    exp_t q[$];

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
        .id_valid_i(v), .id_MemRead_i(mr), .id_MemtoReg_i(m2r),
        .id_ALUOp_i(op), .id_MemWrite_i(mw), .id_ALUSrc_i(as),
        .id_RegWrite_i(rw), .id_rs1_data_i(d1), .id_rs2_data_i(d2),
        .id_imm_i(imm), .id_funct_i(funct), .id_rs1_i(rs1),
        .id_rs2_i(rs2), .id_rd_i(rd), .stall_o(stall),
        .ex_valid_o(e_v), .ex_MemRead_o(e_mr), .ex_MemtoReg_o(e_m2r),
        .ex_ALUOp_o(e_op), .ex_MemWrite_o(e_mw), .ex_ALUSrc_o(e_as),
        .ex_RegWrite_o(e_rw), .ex_rs1_data_o(e_d1),
        .ex_rs2_data_o(e_d2), .ex_imm_o(e_imm), .ex_funct_o(e_funct),
        .ex_rs1_o(e_rs1), .ex_rs2_o(e_rs2), .ex_rd_o(e_rd),
        .bubble_cnt_o(cnt)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
        .id_valid_i(v), .id_MemRead_i(mr), .id_MemtoReg_i(m2r),
        .id_ALUOp_i(op), .id_MemWrite_i(mw), .id_ALUSrc_i(as),
        .id_RegWrite_i(rw), .id_rs1_data_i(d1), .id_rs2_data_i(d2),
        .id_imm_i(imm), .id_funct_i(funct), .id_rs1_i(rs1),
        .id_rs2_i(rs2), .id_rd_i(rd), .stall_o(stall2),
        .ex_valid_o(s_v), .ex_MemRead_o(s_mr), .ex_MemtoReg_o(s_m2r),
        .ex_ALUOp_o(s_op), .ex_MemWrite_o(s_mw), .ex_ALUSrc_o(s_as),
        .ex_RegWrite_o(s_rw), .ex_rs1_data_o(s_d1),
        .ex_rs2_data_o(s_d2), .ex_imm_o(s_imm), .ex_funct_o(s_funct),
        .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2), .ex_rd_o(s_rd),
        .bubble_cnt_o(cnt2)
    );

    task automatic set_instr(input logic iv, input logic imr,
                             input logic im2r, input logic [1:0] iop,
                             input logic imw, input logic ias,
                             input logic irw, input logic [4:0] irs1,
                             input logic [4:0] irs2, input logic [4:0] ird);
        v = iv; mr = imr; m2r = im2r; op = iop;
        mw = imw; as = ias; rw = irw;
        rs1 = irs1; rs2 = irs2; rd = ird;
        d1 = $urandom; d2 = $urandom; imm = $urandom;
        funct = 10'($urandom);
    endtask

    function automatic logic model_hazard();
        return m.valid & m.mr & (m.rd != 5'd0) & v
             & ((m.rd == rs1) | ((m.rd == rs2) & (~as | mw)));
    endfunction

    task automatic step();
        logic h, es;
        exp_t n, a, e;
        #1;
        h  = model_hazard();
        es = h & start & ~flush;
        checks++;
        if (stall !== es || stall2 !== es) begin
            errors++;
            $display("FAIL stall: got %b/%b want %b", stall, stall2, es);
        end
        n = m;
        if (!rst) begin
            n = '0;
        end else if (start) begin
            n.d1 = d1; n.d2 = d2; n.imm = imm; n.funct = funct;
            n.rs1 = rs1; n.rs2 = rs2;
            if (flush || h || !v) begin
                {n.valid, n.mr, n.m2r, n.op, n.mw, n.as, n.rw} = '0;
                n.rd = 5'd0;
            end else begin
                {n.valid, n.mr, n.m2r, n.op, n.mw, n.as, n.rw} =
                    {1'b1, mr, m2r, op, mw, as, rw};
                n.rd = rd;
            end
            if (h && !flush) begin
                if (n.cnt != 16'hffff) n.cnt = n.cnt + 16'd1;
                if (n.cnt2 != 2'b11) n.cnt2 = n.cnt2 + 2'd1;
            end
        end
        q.push_back(n);
        @(posedge clk);
        #1;
        a = {e_v, e_mr, e_m2r, e_op, e_mw, e_as, e_rw, e_d1, e_d2,
             e_imm, e_funct, e_rs1, e_rs2, e_rd, cnt, cnt2};
        e = q.pop_front();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL ex_state: got %h want %h", a, e);
        end
        checks++;
        if ({s_v, s_mr, s_m2r, s_op, s_mw, s_as, s_rw, s_rd} !==
            {e.valid, e.mr, e.m2r, e.op, e.mw, e.as, e.rw, e.rd}) begin
            errors++;
            $display("FAIL sat_ctrl: got %b/%0d want %b/%0d",
                     {s_v, s_mr, s_m2r, s_op, s_mw, s_as, s_rw}, s_rd,
                     {e.valid, e.mr, e.m2r, e.op, e.mw, e.as, e.rw}, e.rd);
        end
        m = e;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b1; flush = 1'b0;
        set_instr(1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1,
                  5'd3, 5'd4, 5'd9);
        step();
        rst = 1'b1;
    endtask

    task automatic load_to(input logic [4:0] r);
        set_instr(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1,
                  5'd1, 5'd0, r);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_instr(1'($urandom), 1'($urandom), 1'($urandom),
                      2'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 5'($urandom), 5'($urandom),
                      5'($urandom));
            step();
        end
        checks++;
        if ({e_v, e_rd, e_d1, e_op, e_rw, cnt, cnt2, stall} !== '0) begin
            errors++;
            $display("FAIL reset: got v=%b rd=%0d d1=%h cnt=%0d stall=%b want 0",
                     e_v, e_rd, e_d1, cnt, stall);
        end
        rst = 1'b1;
    endtask

    task automatic test_passthrough();
        set_instr(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1,
                  5'd1, 5'd2, 5'd5);
        d1 = 32'h1234;
        step();
        checks++;
        if (e_rw !== 1'b1 || e_op !== 2'b10 || e_rd !== 5'd5 ||
            e_d1 !== 32'h1234 || e_v !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL passthrough: got rw=%b op=%b rd=%0d d1=%h stall=%b want 1 10 5 1234 0",
                     e_rw, e_op, e_rd, e_d1, stall);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        load_to(5'd7);
        set_instr(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1,
                  5'd2, 5'd7, 5'd8);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: got %b want 1", stall);
        end
        step();
        checks++;
        if (e_v !== 1'b0 || cnt !== 16'd1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: got v=%b cnt=%0d stall=%b want 0 1 0",
                     e_v, cnt, stall);
        end
        step();
        checks++;
        if (e_v !== 1'b1 || e_rd !== 5'd8 || e_rw !== 1'b1) begin
            errors++;
            $display("FAIL load_use_release: got v=%b rd=%0d want 1 8",
                     e_v, e_rd);
        end
        load_to(5'd7);
        set_instr(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1,
                  5'd2, 5'd7, 5'd9);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL addi_no_stall: got %b want 0", stall);
        end
        step();
    endtask

    task automatic test_x0_store();
        load_to(5'd0);
        set_instr(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1,
                  5'd0, 5'd0, 5'd4);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_no_stall: got %b want 0", stall);
        end
        step();
        load_to(5'd3);
        set_instr(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0,
                  5'd1, 5'd3, 5'd0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL store_stall: got %b want 1", stall);
        end
        step();
        step();
    endtask

    task automatic test_flush();
        logic [15:0] c0;
        load_to(5'd7);
        c0 = cnt;
        set_instr(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1,
                  5'd7, 5'd7, 5'd8);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %b want 0", stall);
        end
        step();
        flush = 1'b0;
        checks++;
        if (e_v !== 1'b0 || cnt !== c0) begin
            errors++;
            $display("FAIL flush_bubble: got v=%b cnt=%0d want 0 %0d",
                     e_v, cnt, c0);
        end
    endtask

    task automatic test_freeze();
        logic [31:0] d1s;
        logic [4:0]  rds;
        set_instr(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1,
                  5'd6, 5'd7, 5'd12);
        step();
        d1s = e_d1;
        rds = e_rd;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0,
                      5'd12, 5'd12, 5'd20);
            step();
        end
        start = 1'b1;
        checks++;
        if (e_d1 !== d1s || e_rd !== rds || e_op !== 2'b01) begin
            errors++;
            $display("FAIL freeze: got d1=%h rd=%0d op=%b want %h %0d 01",
                     e_d1, e_rd, e_op, d1s, rds);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            load_to(5'd7);
            set_instr(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1,
                      5'd7, 5'd1, 5'd8);
            step();
        end
        checks++;
        if (cnt2 !== 2'b11 || cnt !== 16'd5) begin
            errors++;
            $display("FAIL saturation: got cnt2=%0d cnt=%0d want 3 5",
                     cnt2, cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        load_to(5'd7);
        set_instr(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1,
                  5'd7, 5'd1, 5'd8);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || e_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: got stall=%b v=%b want 0 0",
                     stall, e_v);
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            rst   = ($urandom_range(0, 40) != 0);
            start = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 7) == 0);
            set_instr(($urandom_range(0, 5) != 0), 1'($urandom),
                      1'($urandom), 2'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)));
            step();
        end
        rst = 1'b1; start = 1'b1; flush = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
        end
    endtask

    initial begin
        m = '0;
        set_instr(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                  5'd0, 5'd0, 5'd0);
        test_reset();
        test_passthrough();
        test_load_use();
        test_x0_store();
        test_flush();
        test_freeze();
        test_saturation();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the decode/control stage and the execute stage.
- Latches the decode-stage control bits (MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite), operands, immediate, funct bits and register addresses.
- Contains load-use hazard detection: inserts a bubble into EX and raises stall_o to freeze PC and IF/ID.
- Also accepts a flush from branch resolution and keeps a saturating bubble counter for performance debug.

Parameters:
- XLEN, 32, operand/immediate width
- CNT_W, 16, bubble counter width

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-low
- start_i  input  1  high = pipeline runs; low = all state frozen
- flush_i  input  1  squash the instruction currently in ID
- id_valid_i  input  1  ID holds a real instruction
- id_MemRead_i  input  1  decode control bit
- id_MemtoReg_i  input  1  decode control bit
- id_ALUOp_i  input  2  decode control field
- id_MemWrite_i  input  1  decode control bit
- id_ALUSrc_i  input  1  decode control bit
- id_RegWrite_i  input  1  decode control bit
- id_rs1_data_i  input  XLEN  register-file read data 1
- id_rs2_data_i  input  XLEN  register-file read data 2
- id_imm_i  input  XLEN  sign-extended immediate
- id_funct_i  input  10  {funct7, funct3}
- id_rs1_i  input  5  source register address 1
- id_rs2_i  input  5  source register address 2
- id_rd_i  input  5  destination register address
- stall_o  output  1  hold PC and IF/ID this cycle (combinational)
- ex_valid_o  output  1  EX holds a real instruction
- ex_MemRead_o  output  1  registered control bit
- ex_MemtoReg_o  output  1  registered control bit
- ex_ALUOp_o  output  2  registered control field
- ex_MemWrite_o  output  1  registered control bit
- ex_ALUSrc_o  output  1  registered control bit
- ex_RegWrite_o  output  1  registered control bit
- ex_rs1_data_o  output  XLEN  registered operand 1
- ex_rs2_data_o  output  XLEN  registered operand 2
- ex_imm_o  output  XLEN  registered immediate
- ex_funct_o  output  10  registered funct bits
- ex_rs1_o  output  5  registered source address 1
- ex_rs2_o  output  5  registered source address 2
- ex_rd_o  output  5  registered destination address
- bubble_cnt_o  output  CNT_W  count of hazard bubbles inserted

Behaviour:
- Reset: rst_i sampled low at a rising edge clears every registered output and bubble_cnt_o to 0. stall_o is 0 while ex_valid_o is 0.
- Latency: exactly one cycle from id_* to ex_*.
- Hazard detection: hazard = ex_valid_o & ex_MemRead_o & (ex_rd_o != 0) & id_valid_i & (rs1_match | rs2_match).
  - rs1_match = (ex_rd_o == id_rs1_i).
  - rs2_match = (ex_rd_o == id_rs2_i) & (id_ALUSrc_i == 0 | id_MemWrite_i).
- stall_o = hazard & start_i & ~flush_i. Purely combinational; no registered delay.
- Per-edge priority, highest first:
  1. rst_i low: reset.
  2. start_i low: every register holds, including the counter.
  3. flush_i high: bubble.
  4. hazard: bubble, and bubble_cnt_o increments.
  5. Otherwise: normal load of all id_* into ex_*, with ex_valid_o = id_valid_i.
- Bubble definition:
  - ex_valid_o, ex_MemRead_o, ex_MemtoReg_o, ex_MemWrite_o, ex_RegWrite_o, ex_ALUSrc_o and ex_rd_o load 0; ex_ALUOp_o loads 2'b00.
  - Data, imm, funct, rs1 and rs2 still load the id_* values (don't-care to EX, but deterministic).
- Invalid ID on normal load: id_valid_i = 0 loads a bubble-equivalent. All control bits are forced to 0 regardless of the id_* control inputs.
- Counter: bubble_cnt_o counts hazard bubbles only (not flushes) and saturates at all-ones with no wrap.
- Stall duration: one load-use stall lasts exactly one cycle. After the bubble, ex_valid_o = 0, so hazard deasserts and the held instruction enters EX.
- Simultaneous flush and hazard: flush wins, stall_o = 0, counter unchanged.
- Reset mid-stall: the next cycle has stall_o = 0 and EX is empty.

Test Plan:
- Reset: rst_i = 0 for 2 cycles with random id_* -> all ex_* = 0, bubble_cnt_o = 0, stall_o = 0.
- Passthrough: id_RegWrite_i = 1, id_ALUOp_i = 2'b10, id_rd_i = 5, id_rs1_data_i = 32'h1234, valid -> next cycle ex_RegWrite_o = 1, ex_ALUOp_o = 2'b10, ex_rd_o = 5, ex_rs1_data_o = 32'h1234, stall_o = 0.
- Load-use: load to x7 in EX, then ID add with rs2 = 7 and ALUSrc = 0:
  - stall_o = 1 for exactly one cycle, EX gets a bubble, bubble_cnt_o = 1.
  - The add enters EX on the following edge.
  - Repeat with addi (ALUSrc = 1, rs2 field = 7) -> no stall.
- x0 and store-data cases:
  - Load with rd = 0 followed by a consumer of x0 -> stall_o = 0.
  - Load to x3 followed by a store with rs2 = 3 -> stall_o = 1.
- Flush vs hazard: hazard condition with flush_i = 1 -> stall_o = 0, ex_valid_o = 0 next cycle, bubble_cnt_o unchanged.
- Freeze and saturation:
  - start_i = 0 for 3 cycles -> all ex_* unchanged.
  - With CNT_W = 2, force 5 hazards -> bubble_cnt_o stays at 3.
